am2940_dma_ctrl: RTL and testbench
==================================

# am2940_dma_ctrl

Control and word-count stage of the AM2940 DMA address generator. Decodes the 3-bit instruction bus, holds the control, address-initial and word-count registers, runs the word counter and terminal-count logic, and drives the load/enable/direction/carry controls of the downstream 8-bit address counter. Sits directly upstream of the address counter; its `done` output is the DMA channel's transfer-complete flag.

## Interface

- `W`, 8, data/address/word-count width
- `clk` input 1: single clock, all state updates on rising edge
- `reset_n` input 1: synchronous, active-low reset
- `instr_valid` input 1: qualifies `instr` for one cycle
- `instr` input 3: 0 WR_CR, 1 RD_CR, 2 RD_WC, 3 RD_ADDR, 4 REINIT, 5 LD_ADDR, 6 LD_WC, 7 ENABLE
- `di` input W: data bus, operand for WR_CR (bits [2:0]), LD_ADDR, LD_WC
- `cnten` input 1: one transfer per cycle while high in RUN
- `addr_q` input W: current address counter value
- `addr_co` input 1: counter carry; low means the address wraps on this transfer
- `addr_di` output W: load value for the address counter
- `addr_pl`, `addr_enc`, `addr_inc`, `addr_dec`, `addr_cin` output 1 each: address counter controls
- `data_out` output W: read-back data
- `data_oe` output 1: `data_out` valid
- `done` output 1: terminal count reached

## Operation

- Registers: CR[2:0], AR (address initial), WCR (word count initial), WC (word counter), state.
- CR[1:0] mode: 00 count-down-to-zero, 01 count-up-compare, 10 address-boundary, 11 auto-reinitialize. CR[2]: 0 address increments, 1 decrements.
- States: IDLE, RUN, DONE.
- Instructions, when `instr_valid`:
  - WR_CR: CR ← di[2:0].
  - LD_ADDR: AR ← di; `addr_di`=di, `addr_pl`=1.
  - LD_WC: WCR ← di; WC ← di (modes 00/11) or 0 (modes 01/10).
  - WR_CR, LD_ADDR, LD_WC also force IDLE and clear `done`.
  - REINIT: WC reloaded as for LD_WC from WCR; `addr_di`=AR, `addr_pl`=1; → IDLE, `done` cleared.
  - ENABLE: IDLE → RUN; ignored in RUN or DONE.
  - RD_CR / RD_WC / RD_ADDR: see Timing; no state change.
- Transfer: cycle in RUN with `cnten`=1 and no load/REINIT instruction that cycle.
  - `addr_enc`=1 in RUN. `addr_inc`=~CR[2], `addr_dec`=CR[2]. `addr_cin`=0 on a transfer, 1 otherwise.
  - Address counter is idle outside RUN except on `addr_pl`.
- Per-mode behaviour on each transfer:
  - Mode 00: WC decrements. If WC was 1 → DONE. WC=0 at ENABLE gives 2^W transfers; 0 wraps to FF.
  - Mode 01: WC increments. If WC+1 == WCR → DONE. WCR=0 gives 2^W transfers.
  - Mode 10: WC increments (modulo 2^W, informational). If `addr_co`=0 on the transfer → DONE.
  - Mode 11: as mode 00, but on the terminal transfer WC ← WCR, `addr_pl`=1 with `addr_di`=AR (overrides `addr_enc`), and state stays RUN.
- DONE: `addr_cin`=1. Leaves DONE only via WR_CR, LD_ADDR, LD_WC or REINIT.
- Instruction-vs-transfer priority: a load or REINIT instruction in the same cycle as `cnten` wins; the transfer is dropped, and WC and address do not step. RD_* and ENABLE do not block transfers.
- `addr_di` = AR whenever no LD_ADDR is present.

## Timing

- Reset (`reset_n`=0 at edge): CR=WCR=WC=AR=0, IDLE, `done`=0, `data_oe`=0, `data_out`=0. Reset mid-RUN aborts immediately with no further transfers.
- Address-counter controls (`addr_pl/enc/inc/dec/cin/di`) are combinational from registered state, `instr`, `instr_valid`, `cnten` and `addr_co`. The address and WC update on the same edge.
- `done`: registered, high the cycle after the terminal transfer, held in DONE. In mode 11 it is a one-cycle pulse the cycle after each reload.
- Reads: `data_out`/`data_oe` registered, one-cycle latency.
  - `data_out` = {W-3 zeros, CR}, WC, or `addr_q` sampled at the instruction edge.
  - `data_oe` high for exactly one cycle; otherwise `data_out` holds its last value.
- ENABLE issued at edge N: the first transfer can occur at edge N+1.

## Structure

- `am2940_pkg`: instruction enum (8 codes), mode enum (4), state enum (IDLE/RUN/DONE), width constant W.
- One sub-module: `am2940_word_counter` (WC register, load, up/down, terminal-compare outputs). Decode, CR/AR/WCR and the FSM stay in the top module.

## Test plan

- Reset: drive `reset_n`=0 in RUN with `cnten`=1 → next cycle IDLE, `done`=0, `data_oe`=0, `addr_cin`=1.
- Mode 00, inc: WR_CR 000, LD_ADDR 10, LD_WC 3, ENABLE, `cnten` held → exactly 3 transfers, address ends at 13, `done` high, RD_WC returns 0.
- Mode 01, dec: WR_CR 101, LD_ADDR 05, LD_WC 4, ENABLE → 4 transfers, address 01, `done` set; `cnten` pulsed 1-0-1-1-1 still gives 4 transfers.
- Mode 10, inc: LD_ADDR FD → 3 transfers (FD, FE, FF→00), `done` after the wrap; RD_ADDR returns 00.
- Mode 11: LD_ADDR 20, LD_WC 2, 6 cycles of `cnten` → address 20,21,20,21,20…, `done` pulses once per 2 transfers, state stays RUN.
- Collision: LD_WC 7 during RUN with `cnten`=1 → no step that edge, IDLE, WC=7 (mode 00); RD_CR with `cnten` → transfer still occurs, `data_out` = CR next cycle.

Source files
------------

// File: rtl/am2940_pkg.sv
// am2940_pkg: shared types and constants for the AM2940 DMA control stage.
//   W        data/address/word-count width
//   instr_e  3-bit instruction codes
//   mode_e   CR[1:0] operating modes
//   state_e  controller states
//   wc_init  word-counter load value for a given mode
package am2940_pkg;

  localparam int W = 8;

  typedef enum logic [2:0] {
    I_WR_CR   = 3'd0,
    I_RD_CR   = 3'd1,
    I_RD_WC   = 3'd2,
    I_RD_ADDR = 3'd3,
    I_REINIT  = 3'd4,
    I_LD_ADDR = 3'd5,
    I_LD_WC   = 3'd6,
    I_ENABLE  = 3'd7
  } instr_e;

  typedef enum logic [1:0] {
    MODE_DOWN   = 2'd0,
    MODE_UPCMP  = 2'd1,
    MODE_ABOUND = 2'd2,
    MODE_AUTO   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Up-counting modes start from zero and compare against WCR;
  // down-counting modes start from the programmed count.
  function automatic logic [W-1:0] wc_init(input mode_e m, input logic [W-1:0] v);
    return (m == MODE_UPCMP || m == MODE_ABOUND) ? '0 : v;
  endfunction

endpackage

// File: rtl/am2940_dma_ctrl_if.sv
// am2940_dma_ctrl_if: bus between the DMA control stage and the 8-bit
// address counter.
//   addr_q, addr_co                       counter -> control (value, carry, low = wrap)
//   addr_di, addr_pl, addr_enc,
//   addr_inc, addr_dec, addr_cin          control -> counter (load value/strobe,
//                                         enable, direction, active-low carry-in)
interface am2940_dma_ctrl_if;
  import am2940_pkg::*;

  logic [W-1:0] addr_q;
  logic         addr_co;
  logic [W-1:0] addr_di;
  logic         addr_pl;
  logic         addr_enc;
  logic         addr_inc;
  logic         addr_dec;
  logic         addr_cin;

  modport master (
    input  addr_q, addr_co,
    output addr_di, addr_pl, addr_enc, addr_inc, addr_dec, addr_cin
  );

  modport slave (
    output addr_q, addr_co,
    input  addr_di, addr_pl, addr_enc, addr_inc, addr_dec, addr_cin
  );
endinterface

// File: rtl/am2940_word_counter.sv
// am2940_word_counter: word counter register with load, up/down step and
// terminal-count compare.
//   clk, reset_n   clock, synchronous active-low reset
//   load/load_val  load has priority over step
//   step/up        count one transfer, direction
//   wcr            compare value for count-up mode
//   wc             current count
//   tc_down        wc == 1 (this decrement is the last)
//   tc_up          wc + 1 == wcr (this increment is the last)
module am2940_word_counter
  import am2940_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         up,
  input  logic [W-1:0] wcr,
  output logic [W-1:0] wc,
  output logic         tc_down,
  output logic         tc_up
);
  logic [W-1:0] wc_plus1;

  assign wc_plus1 = wc + 1'b1;
  assign tc_down  = (wc == W'(1));
  assign tc_up    = (wc_plus1 == wcr);

  always_ff @(posedge clk) begin
    if (!reset_n)  wc <= '0;
    else if (load) wc <= load_val;
    else if (step) wc <= up ? wc_plus1 : wc - 1'b1;
  end
endmodule

// File: rtl/am2940_dma_ctrl.sv
// am2940_dma_ctrl: control and word-count stage of the AM2940 DMA address
// generator. Decodes instructions, holds CR/AR/WCR, runs the terminal-count
// FSM and drives the downstream address counter.
//   clk, reset_n        clock, synchronous active-low reset
//   instr_valid, instr  instruction strobe and code
//   di                  operand bus
//   cnten               transfer request (one per cycle in RUN)
//   ac                  address-counter bus (master side)
//   data_out, data_oe   registered read-back data and its one-cycle valid
//   done                transfer complete
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | programmed or reset, waiting for ENABLE
// RUN     | transfers counted on cnten
// DONE    | terminal count reached, counter frozen
module am2940_dma_ctrl
  import am2940_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [2:0]        instr,
  input  logic [W-1:0]      di,
  input  logic              cnten,
  am2940_dma_ctrl_if.master ac,
  output logic [W-1:0]      data_out,
  output logic              data_oe,
  output logic              done
);
  logic [2:0]   cr;
  logic [W-1:0] ar;
  logic [W-1:0] wcr;
  logic [W-1:0] wc;
  state_e       state;
  instr_e       op;
  mode_e        mode;
  logic         is_wr_cr, is_ld_addr, is_ld_wc, is_reinit, load_cmd;
  logic         transfer, terminal, auto_reload;
  logic         wc_load, wc_up, tc_down, tc_up;
  logic [W-1:0] wc_load_val;

  assign op         = instr_e'(instr);
  assign mode       = mode_e'(cr[1:0]);
  assign is_wr_cr   = instr_valid && (op == I_WR_CR);
  assign is_ld_addr = instr_valid && (op == I_LD_ADDR);
  assign is_ld_wc   = instr_valid && (op == I_LD_WC);
  assign is_reinit  = instr_valid && (op == I_REINIT);
  assign load_cmd   = is_wr_cr || is_ld_addr || is_ld_wc || is_reinit;

  // Loads win over a same-cycle transfer; reset also kills the transfer so
  // the counter does not step on the aborting edge.
  assign transfer = reset_n && (state == ST_RUN) && cnten && !load_cmd;

  always_comb begin
    terminal = 1'b0;
    case (mode)
      MODE_DOWN, MODE_AUTO: terminal = tc_down;
      MODE_UPCMP:           terminal = tc_up;
      MODE_ABOUND:          terminal = !ac.addr_co;
      default:              terminal = 1'b0;
    endcase
  end

  assign auto_reload = transfer && (mode == MODE_AUTO) && tc_down;

  assign wc_load = is_ld_wc || is_reinit || auto_reload;
  assign wc_up   = (mode == MODE_UPCMP) || (mode == MODE_ABOUND);

  always_comb begin
    wc_load_val = wcr;
    if (is_ld_wc)       wc_load_val = wc_init(mode, di);
    else if (is_reinit) wc_load_val = wc_init(mode, wcr);
  end

  am2940_word_counter u_wc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (wc_load),
    .load_val (wc_load_val),
    .step     (transfer),
    .up       (wc_up),
    .wcr      (wcr),
    .wc       (wc),
    .tc_down  (tc_down),
    .tc_up    (tc_up)
  );

  // Counter's parallel load takes priority over its count enable.
  assign ac.addr_di  = is_ld_addr ? di : ar;
  assign ac.addr_pl  = is_ld_addr || is_reinit || auto_reload;
  assign ac.addr_enc = (state == ST_RUN);
  assign ac.addr_inc = !cr[2];
  assign ac.addr_dec = cr[2];
  assign ac.addr_cin = !transfer;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cr       <= '0;
      ar       <= '0;
      wcr      <= '0;
      state    <= ST_IDLE;
      done     <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      data_oe <= 1'b0;
      // done only persists in DONE; in RUN it is the auto-reload pulse.
      if (state == ST_RUN) done <= 1'b0;
      if (instr_valid) begin
        case (op)
          I_WR_CR: begin
            cr    <= di[2:0];
            state <= ST_IDLE;
            done  <= 1'b0;
          end
          I_LD_ADDR: begin
            ar    <= di;
            state <= ST_IDLE;
            done  <= 1'b0;
          end
          I_LD_WC: begin
            wcr   <= di;
            state <= ST_IDLE;
            done  <= 1'b0;
          end
          I_REINIT: begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
          I_ENABLE: if (state == ST_IDLE) state <= ST_RUN;
          I_RD_CR: begin
            data_out <= {{(W-3){1'b0}}, cr};
            data_oe  <= 1'b1;
          end
          I_RD_WC: begin
            data_out <= wc;
            data_oe  <= 1'b1;
          end
          I_RD_ADDR: begin
            data_out <= ac.addr_q;
            data_oe  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (transfer && terminal) begin
        done <= 1'b1;
        if (mode != MODE_AUTO) state <= ST_DONE;
      end
    end
  end
endmodule

// File: tb/tb_am2940_dma_ctrl.sv
module tb_am2940_dma_ctrl;
  import am2940_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [2:0] instr = 3'd0;
  logic [7:0] di = 8'h00;
  logic       cnten = 1'b0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       done;

  int checks = 0;
  int failures = 0;

  am2940_dma_ctrl_if acif();

  am2940_dma_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .di          (di),
    .cnten       (cnten),
    .ac          (acif),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit address counter: load beats count, carry-in active low,
  // carry-out low when the next count wraps.
  logic [7:0] cnt_q = 8'h00;
  always @(posedge clk) begin
    if (acif.addr_pl) cnt_q <= acif.addr_di;
    else if (acif.addr_enc && !acif.addr_cin)
      cnt_q <= acif.addr_inc ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign acif.addr_q  = cnt_q;
  assign acif.addr_co = acif.addr_inc ? (cnt_q != 8'hFF) : (cnt_q != 8'h00);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    instr_valid = 1'b1;
    instr = op;
    di = d;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] op, output logic [7:0] val,
                          output logic oe1, output logic oe2, output logic [7:0] held);
    issue(op, 8'h00);
    val = data_out;
    oe1 = data_oe;
    tick();
    oe2 = data_oe;
    held = data_out;
  endtask

  task automatic test_reset();
    logic [7:0] v, h;
    logic o1, o2;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b want=0", data_oe); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h want=00", data_out); end
    issue(I_WR_CR, 8'h00);
    issue(I_LD_ADDR, 8'h50);
    issue(I_LD_WC, 8'd100);
    issue(I_ENABLE, 8'h00);
    cnten = 1'b1;
    repeat (3) tick();
    checks++; if (cnt_q !== 8'h53) begin failures++; $display("FAIL run_addr got=%h want=53", cnt_q); end
    reset_n = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrun_done got=%b want=0", done); end
    checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL midrun_oe got=%b want=0", data_oe); end
    checks++; if (acif.addr_cin !== 1'b1) begin failures++; $display("FAIL midrun_cin got=%b want=1", acif.addr_cin); end
    checks++; if (acif.addr_enc !== 1'b0) begin failures++; $display("FAIL midrun_enc got=%b want=0", acif.addr_enc); end
    checks++; if (cnt_q !== 8'h53) begin failures++; $display("FAIL midrun_addr got=%h want=53", cnt_q); end
    reset_n = 1'b1;
    tick();
    cnten = 1'b0;
    checks++; if (cnt_q !== 8'h53) begin failures++; $display("FAIL postreset_addr got=%h want=53", cnt_q); end
    read_reg(I_RD_WC, v, o1, o2, h);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_wc got=%h want=00", v); end
  endtask

  // One programmed run in modes 00/01/10; pat gives cnten per cycle (1 past bit 31)
  task automatic run_case(input logic [2:0] cr, input logic [7:0] a0, input logic [7:0] w0,
                          input logic [31:0] pat, input bit rnd);
    int n, remaining, cyc, extra, first_bad, limit;
    logic c, want, got_b, want_b, o1, o2;
    logic [7:0] exp_addr, exp_wc, v, h;
    issue(I_WR_CR, {5'b0, cr});
    issue(I_LD_ADDR, a0);
    issue(I_LD_WC, w0);
    checks++; if (cnt_q !== a0) begin failures++; $display("FAIL ld_addr got=%h want=%h", cnt_q, a0); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_cleared got=%b want=0", done); end
    case (cr[1:0])
      2'b00, 2'b01: n = (w0 == 8'd0) ? 256 : int'(w0);
      2'b10:        n = cr[2] ? int'(a0) + 1 : 256 - int'(a0);
      default:      n = 0;
    endcase
    exp_addr = cr[2] ? a0 - 8'(n) : a0 + 8'(n);
    exp_wc   = (cr[1:0] == 2'b00) ? 8'h00 : 8'(n);
    issue(I_ENABLE, 8'h00);
    remaining = n; cyc = 0; extra = 0; first_bad = -1;
    got_b = 1'b0; want_b = 1'b0;
    limit = 8 * n + 100;
    while (extra < 3 && cyc < limit) begin
      c = rnd ? ($urandom_range(0, 3) != 0) : ((cyc < 32) ? pat[cyc] : 1'b1);
      cnten = c;
      tick();
      cyc++;
      if (c && remaining > 0) remaining--;
      want = (remaining == 0);
      if (done !== want && first_bad < 0) begin first_bad = cyc; got_b = done; want_b = want; end
      if (remaining == 0) extra++;
    end
    cnten = 1'b0;
    checks++; if (remaining != 0) begin failures++; $display("FAIL run_timeout cr=%b remaining=%0d want=0", cr, remaining); end
    checks++; if (first_bad >= 0) begin failures++; $display("FAIL done_trace cr=%b cycle=%0d got=%b want=%b", cr, first_bad, got_b, want_b); end
    checks++; if (cnt_q !== exp_addr) begin failures++; $display("FAIL final_addr cr=%b got=%h want=%h", cr, cnt_q, exp_addr); end
    read_reg(I_RD_WC, v, o1, o2, h);
    checks++; if (v !== exp_wc) begin failures++; $display("FAIL rd_wc cr=%b got=%h want=%h", cr, v, exp_wc); end
    checks++; if (o1 !== 1'b1 || o2 !== 1'b0) begin failures++; $display("FAIL rd_oe got=%b%b want=10", o1, o2); end
    checks++; if (h !== exp_wc) begin failures++; $display("FAIL dout_hold got=%h want=%h", h, exp_wc); end
    read_reg(I_RD_ADDR, v, o1, o2, h);
    checks++; if (v !== exp_addr) begin failures++; $display("FAIL rd_addr cr=%b got=%h want=%h", cr, v, exp_addr); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_held got=%b want=1", done); end
  endtask

  task automatic run_auto(input logic dir, input logic [7:0] a0, input logic [7:0] w,
                          input int cycles, input bit rnd);
    int t, pos, first_bad;
    logic c, exp_done;
    logic [7:0] exp_addr;
    issue(I_WR_CR, {5'b0, dir, 2'b11});
    issue(I_LD_ADDR, a0);
    issue(I_LD_WC, w);
    issue(I_ENABLE, 8'h00);
    t = 0; first_bad = -1;
    for (int k = 0; k < cycles; k++) begin
      c = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      cnten = c;
      tick();
      if (c) t++;
      pos = t % int'(w);
      exp_addr = dir ? a0 - 8'(pos) : a0 + 8'(pos);
      exp_done = c && (pos == 0);
      if ((cnt_q !== exp_addr || done !== exp_done) && first_bad < 0) begin
        first_bad = k;
        $display("FAIL auto_trace w=%0d cycle=%0d addr got=%h want=%h done got=%b want=%b",
                 w, k, cnt_q, exp_addr, done, exp_done);
      end
    end
    cnten = 1'b0;
    checks++; if (first_bad >= 0) begin failures++; $display("FAIL auto_summary w=%0d first_bad=%0d want=-1", w, first_bad); end
    checks++; if (acif.addr_enc !== 1'b1) begin failures++; $display("FAIL auto_stays_run got=%b want=1", acif.addr_enc); end
  endtask

  task automatic test_mode00();
    run_case(3'b000, 8'h10, 8'd3, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_mode01();
    run_case(3'b101, 8'h05, 8'd4, 32'hFFFF_FFFF, 1'b0);
    run_case(3'b101, 8'h05, 8'd4, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_mode10();
    run_case(3'b010, 8'hFD, 8'd0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_mode11();
    run_auto(1'b0, 8'h20, 8'd2, 6, 1'b0);
    run_auto(1'b1, 8'(($urandom_range(0, 255))), 8'($urandom_range(1, 6)), 40, 1'b1);
    run_auto(1'b0, 8'(($urandom_range(0, 255))), 8'($urandom_range(1, 6)), 40, 1'b1);
  endtask

  task automatic test_collision();
    logic [7:0] v, h;
    logic o1, o2;
    issue(I_WR_CR, 8'h04);
    issue(I_LD_ADDR, 8'h40);
    issue(I_LD_WC, 8'd20);
    issue(I_ENABLE, 8'h00);
    cnten = 1'b1;
    repeat (3) tick();
    checks++; if (cnt_q !== 8'h3D) begin failures++; $display("FAIL coll_pre got=%h want=3d", cnt_q); end
    issue(I_LD_WC, 8'd7);
    checks++; if (cnt_q !== 8'h3D) begin failures++; $display("FAIL coll_nostep got=%h want=3d", cnt_q); end
    checks++; if (acif.addr_enc !== 1'b0) begin failures++; $display("FAIL coll_idle got=%b want=0", acif.addr_enc); end
    tick();
    cnten = 1'b0;
    read_reg(I_RD_WC, v, o1, o2, h);
    checks++; if (v !== 8'd7) begin failures++; $display("FAIL coll_wc got=%h want=07", v); end
    issue(I_ENABLE, 8'h00);
    cnten = 1'b1;
    issue(I_RD_CR, 8'h00);
    cnten = 1'b0;
    checks++; if (cnt_q !== 8'h3C) begin failures++; $display("FAIL rdcr_step got=%h want=3c", cnt_q); end
    checks++; if (data_out !== 8'h04 || data_oe !== 1'b1) begin failures++; $display("FAIL rdcr_data got=%h/%b want=04/1", data_out, data_oe); end
  endtask

  task automatic test_reinit();
    logic [7:0] v, h;
    logic o1, o2;
    issue(I_WR_CR, 8'h00);
    issue(I_LD_ADDR, 8'h80);
    issue(I_LD_WC, 8'd5);
    issue(I_ENABLE, 8'h00);
    cnten = 1'b1;
    repeat (2) tick();
    issue(I_REINIT, 8'h00);
    cnten = 1'b0;
    checks++; if (cnt_q !== 8'h80) begin failures++; $display("FAIL reinit_addr got=%h want=80", cnt_q); end
    checks++; if (acif.addr_enc !== 1'b0) begin failures++; $display("FAIL reinit_idle got=%b want=0", acif.addr_enc); end
    read_reg(I_RD_WC, v, o1, o2, h);
    checks++; if (v !== 8'd5) begin failures++; $display("FAIL reinit_wc got=%h want=05", v); end
  endtask

  task automatic test_random();
    logic [2:0] cr;
    logic [7:0] a0, w0;
    for (int i = 0; i < 8; i++) begin
      cr = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      a0 = 8'($urandom_range(0, 255));
      w0 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      run_case(cr, a0, w0, 32'h0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode01();
    test_mode10();
    test_mode11();
    test_collision();
    test_reinit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
